fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader_pkg.sv | 13 +
 rtl/fifo_reader_skid_buf2.sv | 62 ++++++
 rtl/fifo_reader.sv | 104 ++++++++++
 tb/tb_fifo_reader.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared types and default sizes for the FIFO burst reader.
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DATA_SIZE_DEF = 16;
  localparam int LOG_DEPTH_DEF = 12;

endpackage

// File: rtl/fifo_reader_skid_buf2.sv
// Two-entry in-order output buffer; slot0 is always the head word.
module skid_buf2
  import fifo_reader_pkg::*;
#(
  parameter int data_size = DATA_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 push,
  input  logic [data_size-1:0] push_data,
  input  logic                 pop,
  output logic [1:0]           occ,
  output logic [data_size-1:0] head_data
);

  logic [data_size-1:0] slot0;
  logic [data_size-1:0] slot1;
  logic [1:0]           occ_q;
  logic                 pop_ok;

  assign pop_ok    = pop & (occ_q != 2'd0);
  assign occ       = occ_q;
  assign head_data = slot0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot0 <= '0;
      slot1 <= '0;
      occ_q <= 2'd0;
    end else if (flush) begin
      occ_q <= 2'd0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (occ_q == 2'd0) begin
            slot0 <= push_data;
            occ_q <= 2'd1;
          end else if (occ_q == 2'd1) begin
            slot1 <= push_data;
            occ_q <= 2'd2;
          end
        end
        2'b01: begin
          slot0 <= slot1;
          occ_q <= occ_q - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind whatever remains.
          if (occ_q == 2'd1) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Burst reader: pops a registered-read upstream FIFO and streams words downstream.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | issuing pops and delivering words
//   DONE  | one-cycle completion pulse
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int data_size = DATA_SIZE_DEF,
  parameter int log_depth = LOG_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [log_depth:0]   burst_len,
  input  logic                 abort,
  input  logic                 fifo_empty,
  input  logic [data_size-1:0] fifo_data,
  output logic                 fifo_r_en,
  output logic [data_size-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 done,
  output logic [log_depth:0]   words_out
);

  state_t             state;
  state_t             state_nxt;
  logic [log_depth:0] len_q;
  logic [log_depth:0] issued;
  logic [log_depth:0] words_q;
  logic               inflight;
  logic [1:0]         occ;
  logic [2:0]         pending;
  logic               hs;
  logic               start_ok;
  logic               run_abort;
  logic               buf_push;
  logic               buf_flush;

  assign hs        = m_valid & m_ready;
  assign start_ok  = (state == IDLE) & start;
  assign run_abort = (state == RUN) & abort;
  // Words already committed to the buffer after this cycle's handshake.
  assign pending   = {1'b0, occ} + {2'b00, inflight} - {2'b00, hs};
  assign buf_push  = inflight & (state == RUN) & ~abort;
  assign buf_flush = run_abort | start_ok;

  assign fifo_r_en = (state == RUN) && !abort && !fifo_empty &&
                     (issued < len_q) && (pending < 3'd2);

  assign m_valid   = (occ != 2'd0);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign words_out = words_q;

  skid_buf2 #(.data_size(data_size)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (buf_flush),
    .push      (buf_push),
    .push_data (fifo_data),
    .pop       (hs),
    .occ       (occ),
    .head_data (m_data)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (burst_len == '0) ? DONE : RUN;
      RUN: begin
        if (abort)                 state_nxt = IDLE;
        else if (words_q == len_q) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      len_q    <= '0;
      issued   <= '0;
      words_q  <= '0;
      inflight <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        len_q    <= burst_len;
        issued   <= '0;
        words_q  <= '0;
        inflight <= 1'b0;
      end else begin
        inflight <= fifo_r_en;
        if (fifo_r_en) issued  <= issued + 1'b1;
        if (hs)        words_q <= words_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed and randomized bursts against a queue-based model of the reader.
module tb_fifo_reader;

  localparam int DW = 16;
  localparam int LD = 12;
  localparam int CW = LD + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] burst_len;
  logic          abort;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_r_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          busy;
  logic          done;
  logic [CW-1:0] words_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_reader #(.data_size(DW), .log_depth(LD)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .burst_len  (burst_len),
    .abort      (abort),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_r_en  (fifo_r_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy),
    .done       (done),
    .words_out  (words_out)
  );

  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] wq[$];
  int            pops_b, hs_b, cyc, hs_first, hs_last, force_cnt, ready_mode;
  bit            arm_empty, prev_stall, track_wo, start_noise;
  logic [DW-1:0] prev_data;
  logic          s_r_en, s_valid, s_busy, s_done;
  logic [DW-1:0] s_data;
  logic [CW-1:0] s_wo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: sample and check at negedge, then model FIFO/downstream after posedge.
  task automatic step();
    logic h, p;
    @(negedge clk);
    s_r_en  = fifo_r_en;
    s_valid = m_valid;
    s_data  = m_data;
    s_busy  = busy;
    s_done  = done;
    s_wo    = words_out;
    h = m_valid & m_ready;
    p = fifo_r_en;
    if (fifo_empty) chk("r_en_while_empty", fifo_r_en, 0);
    chk("outstanding_le2", (pops_b - hs_b) <= 2, 1);
    if (track_wo) chk("words_out_count", words_out, hs_b);
    if (prev_stall) begin
      chk("stall_valid", m_valid, 1);
      chk("stall_data", m_data, prev_data);
    end
    if (h) begin
      chk("word_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("word_order", m_data, exp_q.pop_front());
      if (hs_first < 0) hs_first = cyc;
      hs_last = cyc;
    end
    prev_stall = m_valid & ~m_ready & ~abort;
    prev_data  = m_data;
    @(posedge clk);
    #1;
    if (p) begin
      if (fq.size() > 0) fifo_data = fq.pop_front();
      pops_b++;
      if (arm_empty) begin
        force_cnt = 5;
        arm_empty = 0;
      end
    end
    if (h) hs_b++;
    fifo_empty = (fq.size() == 0) || (force_cnt > 0);
    if (force_cnt > 0) force_cnt--;
    cyc++;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ((cyc % 3) == 0);
      2:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = (hs_b < 2);
    endcase
    if (start_noise) begin
      start     = 1'($urandom_range(0, 1));
      burst_len = CW'($urandom);
    end
  endtask

  task automatic make_words(input int len);
    wq.delete();
    for (int i = 0; i < len; i++) wq.push_back(DW'($urandom));
  endtask

  task automatic begin_burst(input int len, input int mode, input bit empty_test, input bit with_abort);
    fq = wq;
    exp_q = wq;
    pops_b = 0;
    hs_b = 0;
    hs_first = -1;
    hs_last = -1;
    cyc = 0;
    ready_mode = mode;
    arm_empty = empty_test;
    force_cnt = 0;
    fifo_empty = (fq.size() == 0);
    m_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    track_wo = 0;
    start = 1'b1;
    abort = with_abort;
    burst_len = CW'(len);
    step();
    start = 1'b0;
    abort = 1'b0;
    track_wo = 1;
  endtask

  task automatic run_burst(input int len, input int mode, input bit empty_test,
                           input bit with_abort, input bit noise);
    int full_idx, done_idx, done_cnt, n;
    full_idx = -1;
    done_idx = -1;
    done_cnt = 0;
    n = 0;
    begin_burst(len, mode, empty_test, with_abort);
    start_noise = noise;
    while (done_cnt == 0 && n < 400) begin
      step();
      if (full_idx < 0 && s_wo == CW'(len)) full_idx = n;
      if (s_done) begin
        done_cnt++;
        done_idx = n;
        start_noise = 0;
        start = 1'b0;
      end else begin
        chk("busy_in_run", s_busy, 1);
      end
      n++;
    end
    start_noise = 0;
    start = 1'b0;
    chk("done_reached", done_cnt, 1);
    repeat (3) begin
      step();
      if (s_done) done_cnt++;
      chk("idle_after_done", s_busy, 0);
    end
    chk("done_once", done_cnt, 1);
    chk("done_timing", done_idx, (len == 0) ? 0 : full_idx + 1);
    chk("words_out_final", s_wo, len);
    chk("all_delivered", exp_q.size(), 0);
    chk("pop_count", pops_b, len);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    burst_len = '0;
    fifo_empty = 1'b1;
    fifo_data = '0;
    m_ready = 1'b1;
    ready_mode = 0;
    prev_stall = 0;
    track_wo = 0;
    start_noise = 0;
    arm_empty = 0;
    force_cnt = 0;
    pops_b = 0;
    hs_b = 0;
    cyc = 0;
    #1;
    chk("rst_r_en", fifo_r_en, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_words", words_out, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Four fixed words at full rate.
    wq = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    run_burst(4, 0, 0, 0, 0);
    chk("throughput", hs_last - hs_first, 3);

    // Back-pressure pattern 1,0,0 repeating.
    make_words(6);
    run_burst(6, 1, 0, 0, 0);

    // Upstream runs empty for five cycles after the first pop.
    make_words(3);
    run_burst(3, 0, 1, 0, 0);

    // Zero-length burst.
    wq.delete();
    run_burst(0, 0, 0, 0, 0);

    // Abort after two accepted words.
    make_words(8);
    begin_burst(8, 3, 0, 0);
    n = 0;
    while (hs_b < 2 && n < 100) begin
      step();
      n++;
    end
    chk("abort_reach2", hs_b, 2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_r_en", s_r_en, 0);
    step();
    chk("abort_busy", s_busy, 0);
    chk("abort_valid", s_valid, 0);
    chk("abort_done", s_done, 0);
    chk("abort_words", s_wo, 2);
    fq.delete();
    exp_q.delete();
    repeat (4) begin
      step();
      chk("post_abort_done", s_done, 0);
      chk("post_abort_valid", s_valid, 0);
    end
    // Abort while idle is a no-op.
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    chk("idle_abort_busy", s_busy, 0);
    chk("idle_abort_words", s_wo, 2);
    make_words(5);
    run_burst(5, 0, 0, 0, 0);

    // Reset mid-burst while a word is presented.
    make_words(8);
    begin_burst(8, 1, 0, 0);
    n = 0;
    while (!(s_valid && hs_b >= 1) && n < 50) begin
      step();
      n++;
    end
    chk("reset_setup_valid", s_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_r_en", fifo_r_en, 0);
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_data", m_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_words", words_out, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    prev_stall = 0;
    track_wo = 0;
    make_words(4);
    fq = wq;
    exp_q.delete();
    pops_b = 0;
    hs_b = 0;
    fifo_empty = 1'b0;
    ready_mode = 0;
    m_ready = 1'b1;
    repeat (4) begin
      step();
      chk("post_rst_valid", s_valid, 0);
      chk("post_rst_r_en", s_r_en, 0);
      chk("post_rst_busy", s_busy, 0);
    end
    make_words(4);
    run_burst(4, 0, 0, 0, 0);

    // Randomized bursts: random lengths and back-pressure, stray start pulses,
    // and start together with abort in IDLE.
    for (int b = 0; b < 6; b++) begin
      int len;
      len = $urandom_range(1, 10);
      make_words(len);
      run_burst(len, 2, 0, (b % 2) == 1, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
